// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with MIPS HI/LO registers.
// Each operation takes 32 shift-add (multiply) or restoring shift-subtract
// (divide) steps on unsigned magnitudes, then one sign-correction cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; MTHI/MTLO writes accepted here
// S_RUN  | 32 iteration steps, counter counts down to terminal 0
// S_FIX  | sign correction, HI/LO written at the end of this cycle
// S_DONE | done pulse (plus div_by_zero when the divisor was 0)
module mips_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Operand magnitudes; signed ops have op[0]=0. The magnitude of
    // 0x80000000 is 0x80000000 read as unsigned, which the datapath handles.
    logic        signed_op;
    logic [31:0] a_mag, b_mag;
    assign signed_op = ~op[0];
    assign a_mag = (signed_op && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
    assign b_mag = (signed_op && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide step: acc = {partial remainder, dividend bits / quotient bits}.
    // When the trial subtraction succeeds the true difference is below the
    // divisor, so a 32-bit modular subtract is exact.
    logic [32:0] div_shift;
    logic        div_take;
    logic [31:0] div_sub;
    logic [63:0] div_next;
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_take  = (div_shift >= {1'b0, opnd_q});
    assign div_sub   = div_shift[31:0] - opnd_q;
    assign div_next  = div_take ? {div_sub, acc_q[30:0], 1'b1}
                                : {div_shift[31:0], acc_q[30:0], 1'b0};

    // Sign-corrected results used in S_FIX.
    logic [63:0] mul_fix;
    logic [31:0] quo_fix, rem_fix;
    assign mul_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    // Next-state, datapath and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        busy        = 1'b0;
        done        = 1'b0;
        div_by_zero = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    cnt_d     = 5'd31;
                    is_div_d  = op[1];
                    neg_res_d = signed_op & (rs_val[31] ^ rt_val[31]);
                    neg_rem_d = signed_op & op[1] & rs_val[31];
                    dz_d      = op[1] & (rt_val == 32'd0);
                    opnd_d    = op[1] ? b_mag : a_mag;
                    acc_d     = op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q == 5'd0) state_d = S_FIX;
                else               cnt_d   = cnt_q - 5'd1;
            end
            S_FIX: begin
                busy    = 1'b1;
                state_d = S_DONE;
                if (!dz_q) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = mul_fix[63:32];
                        lo_d = mul_fix[31:0];
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                div_by_zero = dz_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: expected HI/LO/div_by_zero come from a
// behavioural model and are queued at start, then popped at the done pulse.
module tb_mips_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    mips_muldiv dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    int          n_assert;
    int          n_fail;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] h0,
                                   input logic [31:0] l0);
        exp_t        e;
        logic [63:0] p;
        e.hi = h0;
        e.lo = l0;
        e.dz = 1'b0;
        case (o)
            2'b00: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) e.dz = 1'b1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'd0;
                end else begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 32'd0) e.dz = 1'b1;
                else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Runs one operation: start is sampled at edge 0; busy must be seen in
    // the 33 cycles after edges 0..32 and done in the cycle after edge 33.
    // inj: a second start and MTHI/MTLO while busy, and start during done.
    // wr: MTHI/MTLO asserted together with start (must be discarded).
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit inj, input bit wr);
        exp_t e;
        exp_t got;
        int   k;
        int   bc;
        int   dzbad;
        e = model(o, a, b, hi_m, lo_m);
        sb.push_back(e);
        hi_m = e.hi;
        lo_m = e.lo;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        mthi   = wr;
        mtlo   = wr;
        wdata  = 32'hDEAD_BEEF;
        tick();
        start  = 1'b0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        op     = 2'($urandom_range(3));
        k = 0;
        bc = 0;
        dzbad = 0;
        while (k < 100) begin
            if (done) break;
            if (busy) bc++;
            if (div_by_zero) dzbad++;
            start = inj && (k == 4);
            mthi  = inj && (k == 7);
            mtlo  = inj && (k == 7);
            wdata = 32'hFFFF_0000;
            tick();
            k++;
        end
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check({tag, "_done_cycle"}, 64'(k), 64'd33);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
        check({tag, "_dz_without_done"}, 64'(dzbad), 64'd0);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, "_hi"}, 64'(hi), 64'(got.hi));
            check({tag, "_lo"}, 64'(lo), 64'(got.lo));
            check({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(got.dz));
        end
        start = inj;
        tick();
        start = 1'b0;
        check({tag, "_done_pulse_end"}, 64'(done), 64'd0);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int  k;
        bit  saw_done;

        n_assert = 0;
        n_fail   = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = 32'd0;
        rt_val = 32'd0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        wdata  = 32'd0;
        hi_m   = 32'd0;
        lo_m   = 32'd0;
        tick();
        tick();
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);

        // start while in reset is ignored
        start = 1'b1;
        op    = 2'b01;
        tick();
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check("start_in_reset", 64'(busy), 64'd0);

        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);
        do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        do_op("div_negdivisor", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("div_bothneg", 2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b0);

        // MTHI then MTLO, each visible after the next edge
        mthi  = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        mthi  = 1'b0;
        hi_m  = 32'h0000_1234;
        check("mthi_hi", 64'(hi), 64'(hi_m));
        check("mthi_lo_kept", 64'(lo), 64'(lo_m));
        mtlo  = 1'b1;
        wdata = 32'h0000_5678;
        tick();
        mtlo  = 1'b0;
        lo_m  = 32'h0000_5678;
        check("mtlo_lo", 64'(lo), 64'(lo_m));
        do_op("divu_by_zero", 2'b11, 32'h0000_0064, 32'h0000_0000, 1'b0, 1'b0);

        // both writes together
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hCAFE_BABE;
        tick();
        mthi  = 1'b0;
        mtlo  = 1'b0;
        hi_m  = 32'hCAFE_BABE;
        lo_m  = 32'hCAFE_BABE;
        check("mthilo_hi", 64'(hi), 64'(hi_m));
        check("mthilo_lo", 64'(lo), 64'(lo_m));

        // start with MTHI/MTLO: writes discarded, divide-by-zero keeps HI/LO
        do_op("start_with_mt", 2'b10, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1);
        do_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            do_op("random", 2'(i), $urandom, $urandom | 32'd1, 1'b0, 1'b0);
        end

        // reset during RUN aborts the operation
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd7;
        rt_val = 32'd6;
        tick();
        start    = 1'b0;
        saw_done = 1'b0;
        for (k = 0; k < 10; k++) begin
            if (done) saw_done = 1'b1;
            if (k == 9) check("abort_busy_before", 64'(busy), 64'd1);
            start = (k == 4);
            rst_n = (k != 9);
            tick();
        end
        start = 1'b0;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
        check("abort_run_busy", 64'(busy), 64'd0);
        check("abort_run_done", 64'(done), 64'd0);
        check("abort_run_hi", 64'(hi), 64'd0);
        check("abort_run_lo", 64'(lo), 64'd0);
        check("abort_run_no_done", 64'(saw_done), 64'd0);
        rst_n = 1'b1;
        tick();
        do_op("after_abort", 2'b01, 32'd7, 32'd6, 1'b0, 1'b0);

        // reset in FIX: the pending HI/LO write must not happen
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h1111_1111;
        tick();
        mthi  = 1'b0;
        mtlo  = 1'b0;
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd100;
        rt_val = 32'd7;
        tick();
        start = 1'b0;
        for (k = 0; k < 32; k++) tick();
        check("fix_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
        check("abort_fix_hi", 64'(hi), 64'd0);
        check("abort_fix_lo", 64'(lo), 64'd0);
        check("abort_fix_done", 64'(done), 64'd0);
        check("abort_fix_busy", 64'(busy), 64'd0);
        tick();
        do_op("after_fix_abort", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
